ram_row_select_ctrl: RTL and testbench
======================================

Name: ram_row_select_ctrl

Overview:
Parametrised row-select controller for the structural RAM arrays used in the FIFO modules. It replaces the fixed 5-to-32 combinational decode with registered one-hot write/read row selects. It has two modes: a direct-address mode, and an auto-increment FIFO-pointer mode with occupancy tracking, full/empty flags, accept handshakes and sticky error flags. It sits between the FIFO front end and the RAM word array.

Parameters:
ADDR_W, 5, row address width; minimum 3.
DEPTH, 2**ADDR_W, number of rows. Derived; not overridden independently.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
mode  in  1  0 = direct address, 1 = auto FIFO pointers
wr_req  in  1  write row request
rd_req  in  1  read row request
wr_addr  in  ADDR_W  write row address (direct mode only)
rd_addr  in  ADDR_W  read row address (direct mode only)
wr_sel  out  DEPTH  registered one-hot write row enable
rd_sel  out  DEPTH  registered one-hot read row select
wr_ack  out  1  write accepted (pulse, aligned with wr_sel)
rd_ack  out  1  read accepted (pulse, aligned with rd_sel)
wr_ptr  out  ADDR_W  next write row (auto mode)
rd_ptr  out  ADDR_W  next read row (auto mode)
count  out  ADDR_W+1  occupancy, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0
ovf_err  out  1  sticky: write refused while full
udf_err  out  1  sticky: read refused while empty

Behaviour:
- Reset (rst=1 at a clk edge): wr_sel=0, rd_sel=0, wr_ack=0, rd_ack=0, wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, ovf_err=0, udf_err=0. Reset overrides any request in the same cycle, including mid-burst.
- All outputs are registered. Latency is 1 cycle from the request edge to the sel/ack edge.
- wr_sel and rd_sel are 0 or exactly one-hot, and are valid for one cycle per accepted request. Otherwise they are 0.
- Direct mode (mode=0):
  - wr_req -> wr_sel = onehot(wr_addr), wr_ack=1.
  - rd_req -> rd_sel = onehot(rd_addr), rd_ack=1.
  - Both may occur in the same cycle, including to the same address.
  - Pointers, count, flags and error flags hold.
- Auto mode (mode=1):
  - Read accepted iff rd_req && !empty.
  - Write accepted iff wr_req && (!full || rd_req). When full, a simultaneous read frees the row.
  - Accepted write: wr_sel = onehot(wr_ptr), wr_ptr <= wr_ptr+1 mod DEPTH (wraps DEPTH-1 -> 0).
  - Accepted read: rd_sel = onehot(rd_ptr), rd_ptr <= rd_ptr+1 mod DEPTH.
  - count: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
  - full/empty are derived from the next count and registered with it.
  - Refused write (wr_req && full && !rd_req) sets ovf_err.
  - Refused read (rd_req && empty) sets udf_err.
  - Empty with both requests: write accepted, read refused, udf_err set, count -> 1.
- Mode changes take effect at the next edge. Pointers and count are preserved across mode changes and are not reset.
- Error flags clear only on rst.
- Decode structure: the upper ADDR_W-3 bits are predecoded to enables; each enable gates an 8-way decoder of the low 3 bits.

Decomposition:
- Shared package: mode encodings MODE_DIRECT=0, MODE_AUTO=1; ADDR_W default; DEPTH derivation function.
- One sub-module: onehot_decoder (params IN_W; ports sel, en, out). Combinational. Instantiated once as the predecoder and 2**(ADDR_W-3) times as 8-way decoders, for each of the wr and rd paths.

Test Plan:
- Reset, then mode=0, wr_req with wr_addr=5'd19 -> next cycle wr_sel=32'h0008_0000, wr_ack=1; following cycle wr_sel=0; count=0, empty=1.
- mode=1, 32 consecutive wr_req -> wr_sel walks bit0..bit31, wr_ptr wraps to 0, count=32, full=1. A 33rd wr_req alone -> no wr_ack, wr_sel=0, ovf_err=1.
- Full, wr_req and rd_req together -> wr_sel=bit0, rd_sel=bit0, both acks=1, count stays 32, full stays 1.
- Empty, wr_req and rd_req together -> wr_ack=1, rd_ack=0, udf_err=1, count=1, empty=0.
- 3 writes, then rst asserted in the same cycle as a 4th wr_req -> all outputs at reset values next cycle, errors cleared.
- ADDR_W=4 build: write 10 rows, switch to mode=0 and read rd_addr=4'd3 -> rd_sel=16'h0008, count stays 10. Return to mode=1, read -> rd_sel=16'h0001.

Source files
------------

// File: rtl/ram_row_select_ctrl_pkg.sv
// ============================================================================
// Module      : ram_row_select_ctrl_pkg
// Description : Shared mode encodings, address width default and depth helper
//               for the RAM row-select controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_row_select_ctrl_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_e;

    localparam int ADDR_W_DEFAULT = 5;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/onehot_decoder.sv
// ============================================================================
// Module      : onehot_decoder
// Description : Enable-gated binary to one-hot decoder; output is all-zero
//               while en is low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_decoder #(
    parameter int IN_W = 3
) (
    input  logic [IN_W-1:0]      sel,
    input  logic                 en,
    output logic [(2**IN_W)-1:0] out
);

    always_comb begin
        out = '0;
        if (en) begin
            out[sel] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_row_select_ctrl.sv
// ============================================================================
// Module      : ram_row_select_ctrl
// Description : Registered one-hot write/read row selects for a RAM word
//               array, with direct-address and auto FIFO-pointer modes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_row_select_ctrl
    import ram_row_select_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           mode,
    input  logic                           wr_req,
    input  logic                           rd_req,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [ADDR_W-1:0]              rd_addr,
    output logic [depth_of(ADDR_W)-1:0]    wr_sel,
    output logic [depth_of(ADDR_W)-1:0]    rd_sel,
    output logic                           wr_ack,
    output logic                           rd_ack,
    output logic [ADDR_W-1:0]              wr_ptr,
    output logic [ADDR_W-1:0]              rd_ptr,
    output logic [ADDR_W:0]                count,
    output logic                           full,
    output logic                           empty,
    output logic                           ovf_err,
    output logic                           udf_err
);

    localparam int                DEPTH      = depth_of(ADDR_W);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);
    localparam int                PATH_WR    = 0;
    localparam int                PATH_RD    = 1;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]  wr_sel_q,  wr_sel_d;
    logic [DEPTH-1:0]  rd_sel_q,  rd_sel_d;
    logic              wr_ack_q,  wr_ack_d;
    logic              rd_ack_q,  rd_ack_d;
    logic [ADDR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [ADDR_W:0]   count_q,   count_d;
    logic              full_q,    full_d;
    logic              empty_q,   empty_d;
    logic              ovf_err_q, ovf_err_d;
    logic              udf_err_q, udf_err_d;

    // Per-path decode request: index PATH_WR / PATH_RD
    logic [1:0][ADDR_W-1:0] w_row;
    logic [1:0]             w_go;
    logic [1:0][DEPTH-1:0]  w_dec;

    logic w_auto;
    logic w_wr_acc;
    logic w_rd_acc;

    assign w_auto = (mode_e'(mode) == MODE_AUTO);

    // ------------------------------------------------------------------
    // Acceptance, pointer and occupancy update
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_acc  = 1'b0;
        w_rd_acc  = 1'b0;
        w_row     = '0;
        w_go      = '0;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_err_d = ovf_err_q;
        udf_err_d = udf_err_q;

        if (w_auto) begin
            // A read frees a row in the same cycle, so a full FIFO still
            // accepts a write that arrives together with a read.
            w_rd_acc = rd_req && !empty_q;
            w_wr_acc = wr_req && (!full_q || rd_req);
            w_row[PATH_WR] = wr_ptr_q;
            w_row[PATH_RD] = rd_ptr_q;

            if (w_wr_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (w_rd_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end

            case ({w_wr_acc, w_rd_acc})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase

            if (wr_req && !w_wr_acc) begin
                ovf_err_d = 1'b1;
            end
            if (rd_req && !w_rd_acc) begin
                udf_err_d = 1'b1;
            end
        end else begin
            w_wr_acc = wr_req;
            w_rd_acc = rd_req;
            w_row[PATH_WR] = wr_addr;
            w_row[PATH_RD] = rd_addr;
        end

        w_go[PATH_WR] = w_wr_acc;
        w_go[PATH_RD] = w_rd_acc;

        full_d   = (count_d == FULL_COUNT);
        empty_d  = (count_d == '0);
        wr_ack_d = w_wr_acc;
        rd_ack_d = w_rd_acc;
    end

    // ------------------------------------------------------------------
    // Two-level row decode: upper bits pick a bank of 8 rows, the low three
    // bits pick the row inside the bank.
    // ------------------------------------------------------------------
    for (genvar p = 0; p < 2; p++) begin : g_path
        if (ADDR_W > 3) begin : g_predec
            localparam int PRE_W = ADDR_W - 3;
            localparam int NGRP  = 2 ** PRE_W;

            logic [NGRP-1:0] w_grp_en;

            onehot_decoder #(
                .IN_W (PRE_W)
            ) u_predec (
                .sel (w_row[p][ADDR_W-1:3]),
                .en  (w_go[p]),
                .out (w_grp_en)
            );

            for (genvar g = 0; g < NGRP; g++) begin : g_bank
                onehot_decoder #(
                    .IN_W (3)
                ) u_dec8 (
                    .sel (w_row[p][2:0]),
                    .en  (w_grp_en[g]),
                    .out (w_dec[p][g*8 +: 8])
                );
            end
        end else begin : g_flat
            onehot_decoder #(
                .IN_W (3)
            ) u_dec8 (
                .sel (w_row[p]),
                .en  (w_go[p]),
                .out (w_dec[p])
            );
        end
    end

    assign wr_sel_d = w_dec[PATH_WR];
    assign rd_sel_d = w_dec[PATH_RD];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel_q  <= '0;
            rd_sel_q  <= '0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_err_q <= 1'b0;
            udf_err_q <= 1'b0;
        end else begin
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            wr_ack_q  <= wr_ack_d;
            rd_ack_q  <= rd_ack_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_err_q <= ovf_err_d;
            udf_err_q <= udf_err_d;
        end
    end

    assign wr_sel  = wr_sel_q;
    assign rd_sel  = rd_sel_q;
    assign wr_ack  = wr_ack_q;
    assign rd_ack  = rd_ack_q;
    assign wr_ptr  = wr_ptr_q;
    assign rd_ptr  = rd_ptr_q;
    assign count   = count_q;
    assign full    = full_q;
    assign empty   = empty_q;
    assign ovf_err = ovf_err_q;
    assign udf_err = udf_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_row_select_ctrl.sv
// ============================================================================
// Module      : tb_ram_row_select_ctrl
// Description : Self-checking bench for ram_row_select_ctrl at ADDR_W=5 and
//               ADDR_W=4, against an integer-level FIFO occupancy model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_row_select_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, mode, wr_req, rd_req;
    logic [4:0] wr_addr, rd_addr;

    logic [31:0] wsel5, rsel5;
    logic        wack5, rack5, full5, empty5, ovf5, udf5;
    logic [4:0]  wp5, rp5;
    logic [5:0]  cnt5;

    logic [15:0] wsel4, rsel4;
    logic        wack4, rack4, full4, empty4, ovf4, udf4;
    logic [3:0]  wp4, rp4;
    logic [4:0]  cnt4;

    ram_row_select_ctrl #(.ADDR_W(5)) dut5 (
        .clk(clk), .rst(rst), .mode(mode), .wr_req(wr_req), .rd_req(rd_req),
        .wr_addr(wr_addr), .rd_addr(rd_addr),
        .wr_sel(wsel5), .rd_sel(rsel5), .wr_ack(wack5), .rd_ack(rack5),
        .wr_ptr(wp5), .rd_ptr(rp5), .count(cnt5), .full(full5), .empty(empty5),
        .ovf_err(ovf5), .udf_err(udf5)
    );

    ram_row_select_ctrl #(.ADDR_W(4)) dut4 (
        .clk(clk), .rst(rst), .mode(mode), .wr_req(wr_req), .rd_req(rd_req),
        .wr_addr(wr_addr[3:0]), .rd_addr(rd_addr[3:0]),
        .wr_sel(wsel4), .rd_sel(rsel4), .wr_ack(wack4), .rd_ack(rack4),
        .wr_ptr(wp4), .rd_ptr(rp4), .count(cnt4), .full(full4), .empty(empty4),
        .ovf_err(ovf4), .udf_err(udf4)
    );

    // FIFO abstraction: integer pointers and occupancy, one-hot as 1<<row
    typedef struct {
        int              wp;
        int              rp;
        int              cnt;
        bit              ovf;
        bit              udf;
        longint unsigned wsel;
        longint unsigned rsel;
        bit              wack;
        bit              rack;
    } mdl_t;

    function automatic mdl_t step(input mdl_t m, input int d, input bit r,
                                  input bit md, input bit w, input bit rq,
                                  input int wa, input int ra);
        mdl_t n;
        bit   wacc, racc;
        n = m;
        n.wsel = 0; n.rsel = 0; n.wack = 0; n.rack = 0;
        if (r) begin
            n.wp = 0; n.rp = 0; n.cnt = 0; n.ovf = 0; n.udf = 0;
            return n;
        end
        if (!md) begin
            if (w)  begin n.wsel = 64'd1 << (wa % d); n.wack = 1; end
            if (rq) begin n.rsel = 64'd1 << (ra % d); n.rack = 1; end
            return n;
        end
        racc = rq && (m.cnt != 0);
        wacc = w && ((m.cnt != d) || rq);
        if (wacc) begin n.wsel = 64'd1 << m.wp; n.wack = 1; n.wp = (m.wp + 1) % d; end
        if (racc) begin n.rsel = 64'd1 << m.rp; n.rack = 1; n.rp = (m.rp + 1) % d; end
        n.cnt = m.cnt + (wacc ? 1 : 0) - (racc ? 1 : 0);
        if (w && !wacc)  n.ovf = 1;
        if (rq && !racc) n.udf = 1;
        return n;
    endfunction

    mdl_t m5 = '{default: 0};
    mdl_t m4 = '{default: 0};

    always @(posedge clk) begin
        m5 <= step(m5, 32, rst, mode, wr_req, rd_req, int'(wr_addr), int'(rd_addr));
        m4 <= step(m4, 16, rst, mode, wr_req, rd_req, int'(wr_addr), int'(rd_addr));
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m5.wr_sel",  wsel5, m5.wsel);
            chk("m5.rd_sel",  rsel5, m5.rsel);
            chk("m5.wr_ack",  wack5, m5.wack);
            chk("m5.rd_ack",  rack5, m5.rack);
            chk("m5.wr_ptr",  wp5,   m5.wp);
            chk("m5.rd_ptr",  rp5,   m5.rp);
            chk("m5.count",   cnt5,  m5.cnt);
            chk("m5.full",    full5, m5.cnt == 32);
            chk("m5.empty",   empty5, m5.cnt == 0);
            chk("m5.ovf_err", ovf5,  m5.ovf);
            chk("m5.udf_err", udf5,  m5.udf);
            chk("m4.wr_sel",  wsel4, m4.wsel);
            chk("m4.rd_sel",  rsel4, m4.rsel);
            chk("m4.wr_ack",  wack4, m4.wack);
            chk("m4.rd_ack",  rack4, m4.rack);
            chk("m4.wr_ptr",  wp4,   m4.wp);
            chk("m4.rd_ptr",  rp4,   m4.rp);
            chk("m4.count",   cnt4,  m4.cnt);
            chk("m4.full",    full4, m4.cnt == 16);
            chk("m4.empty",   empty4, m4.cnt == 0);
            chk("m4.ovf_err", ovf4,  m4.ovf);
            chk("m4.udf_err", udf4,  m4.udf);
        end
    end

    // Drive one cycle; returns at the following falling edge with results settled
    task automatic cyc(input bit r, input bit md, input bit w, input bit rq,
                       input int wa, input int ra);
        rst = r; mode = md; wr_req = w; rd_req = rq;
        wr_addr = 5'(wa); rd_addr = 5'(ra);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; rd_addr = '0;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk_en = 1;

        chk("rst.wr_sel", wsel5, 32'h0);
        chk("rst.count",  cnt5, 6'd0);
        chk("rst.empty",  empty5, 1'b1);
        chk("rst.full",   full5, 1'b0);
        chk("rst.ovf",    ovf5, 1'b0);

        // Direct write to row 19
        cyc(0, 0, 1, 0, 19, 0);
        chk("dir.wr_sel19", wsel5, 32'h0008_0000);
        chk("dir.wr_ack",   wack5, 1'b1);
        chk("mdl.wr_sel19", m5.wsel, 64'h0008_0000);
        chk("dir4.wr_sel3", wsel4, 16'h0008);
        cyc(0, 0, 0, 0, 0, 0);
        chk("dir.wr_sel_clr", wsel5, 32'h0);
        chk("dir.count",      cnt5, 6'd0);
        chk("dir.empty",      empty5, 1'b1);

        // Fill all 32 rows in auto mode
        for (int i = 0; i < 32; i++) begin
            cyc(0, 1, 1, 0, 0, 0);
            chk("walk.wr_sel", wsel5, 32'h1 << i);
        end
        chk("fill.wr_ptr", wp5, 5'd0);
        chk("fill.count",  cnt5, 6'd32);
        chk("fill.full",   full5, 1'b1);
        chk("mdl.fill",    m5.cnt, 32);

        cyc(0, 1, 1, 0, 0, 0);
        chk("ovf.wr_ack", wack5, 1'b0);
        chk("ovf.wr_sel", wsel5, 32'h0);
        chk("ovf.err",    ovf5, 1'b1);

        // Full with simultaneous read and write
        cyc(0, 1, 1, 1, 0, 0);
        chk("fullrw.wr_sel", wsel5, 32'h1);
        chk("fullrw.rd_sel", rsel5, 32'h1);
        chk("fullrw.wr_ack", wack5, 1'b1);
        chk("fullrw.rd_ack", rack5, 1'b1);
        chk("fullrw.count",  cnt5, 6'd32);
        chk("fullrw.full",   full5, 1'b1);

        // Empty with simultaneous read and write
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 0);
        chk("emptyrw.wr_ack", wack5, 1'b1);
        chk("emptyrw.rd_ack", rack5, 1'b0);
        chk("emptyrw.udf",    udf5, 1'b1);
        chk("emptyrw.count",  cnt5, 6'd1);
        chk("emptyrw.empty",  empty5, 1'b0);

        // Reset mid-burst clears everything including sticky errors
        cyc(1, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        chk("burst.udf_set", udf5, 1'b1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, 0);
        chk("burst.count3", cnt5, 6'd3);
        cyc(1, 1, 1, 0, 0, 0);
        chk("burst.wr_sel", wsel5, 32'h0);
        chk("burst.wr_ack", wack5, 1'b0);
        chk("burst.wr_ptr", wp5, 5'd0);
        chk("burst.count",  cnt5, 6'd0);
        chk("burst.empty",  empty5, 1'b1);
        chk("burst.udf",    udf5, 1'b0);

        // Ten writes, a direct read of row 3, then an auto read
        for (int i = 0; i < 10; i++) cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 3);
        chk("a4.dir_rd_sel", rsel4, 16'h0008);
        chk("a4.dir_count",  cnt4, 5'd10);
        chk("a4.dir_rd_ack", rack4, 1'b1);
        cyc(0, 1, 0, 1, 0, 0);
        chk("a4.auto_rd_sel", rsel4, 16'h0001);
        chk("a4.auto_count",  cnt4, 5'd9);

        // Randomised traffic, alternating write-heavy and read-heavy phases
        for (int i = 0; i < 3000; i++) begin
            bit r, md, w, rq;
            r  = ($urandom % 97) == 0;
            md = ($urandom % 5) != 0;
            if (((i / 150) % 2) == 0) begin
                w  = ($urandom % 4) != 0;
                rq = ($urandom % 4) == 0;
            end else begin
                w  = ($urandom % 4) == 0;
                rq = ($urandom % 4) != 0;
            end
            cyc(r, md, w, rq, int'($urandom % 32), int'($urandom % 32));
        end

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
